// File: rtl/ntt_cmd_dispatcher.sv
// Command FIFO and issue sequencer in front of the NTT engine: queues host
// LOAD/STORE/NTT/INTT commands and hands them to the engine one at a time.
module ntt_cmd_dispatcher #(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 65536
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     host_valid,
    output logic                     host_ready,
    input  logic [7:0]               host_opcode,
    input  logic [3:0]               host_slot,
    input  logic [47:0]              host_dma_addr,
    output logic                     eng_cmd_valid,
    output logic [7:0]               eng_cmd_opcode,
    output logic [3:0]               eng_cmd_slot,
    output logic [47:0]              eng_cmd_dma_addr,
    input  logic                     eng_ready,
    input  logic                     err_clr,
    output logic [$clog2(DEPTH):0]   queue_level,
    output logic                     idle,
    output logic                     done_pulse,
    output logic [31:0]              done_count,
    output logic                     err_illegal,
    output logic                     err_timeout
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam int EW = 8 + 4 + 48;

    localparam logic [AW-1:0] PTR_ONE      = AW'(1);
    localparam logic [LW-1:0] LVL_ONE      = LW'(1);
    localparam logic [LW-1:0] LVL_FULL     = LW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE      = CW'(1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT - 1);

    localparam logic [7:0] OP_LOAD  = 8'h02;
    localparam logic [7:0] OP_STORE = 8'h03;
    localparam logic [7:0] OP_NTT   = 8'h10;
    localparam logic [7:0] OP_INTT  = 8'h11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_LOW,
        S_WAIT_HIGH
    } state_t;

    state_t         state_q, state_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]  level_q, level_d;
    logic           cmd_valid_q, cmd_valid_d;
    logic [7:0]     cmd_opcode_q, cmd_opcode_d;
    logic [3:0]     cmd_slot_q, cmd_slot_d;
    logic [47:0]    cmd_addr_q, cmd_addr_d;
    logic [CW-1:0]  wait_cnt_q, wait_cnt_d;
    logic           done_pulse_q, done_pulse_d;
    logic [31:0]    done_count_q, done_count_d;
    logic           err_illegal_q, err_illegal_d;
    logic           err_timeout_q, err_timeout_d;

    logic [EW-1:0]  fifo_mem [DEPTH];
    logic [EW-1:0]  head_entry;

    logic opcode_legal;
    logic fifo_empty;
    logic fifo_full;
    logic host_accept;
    logic push;
    logic pop;
    logic illegal_evt;
    logic timeout_evt;

    always_comb begin
        opcode_legal = (host_opcode == OP_LOAD)  || (host_opcode == OP_STORE) ||
                       (host_opcode == OP_NTT)   || (host_opcode == OP_INTT);
        fifo_empty   = (level_q == '0);
        fifo_full    = (level_q == LVL_FULL);
        host_accept  = host_valid && !fifo_full;
        push         = host_accept && opcode_legal;
        illegal_evt  = host_accept && !opcode_legal;
        head_entry   = fifo_mem[rd_ptr_q];
    end

    // Illegal opcodes are swallowed here so they never occupy a FIFO entry.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {host_opcode, host_slot, host_dma_addr};
        end
    end

    always_comb begin
        state_d      = state_q;
        pop          = 1'b0;
        cmd_valid_d  = 1'b0;
        cmd_opcode_d = cmd_opcode_q;
        cmd_slot_d   = cmd_slot_q;
        cmd_addr_d   = cmd_addr_q;
        wait_cnt_d   = wait_cnt_q;
        done_pulse_d = 1'b0;
        done_count_d = done_count_q;
        timeout_evt  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!fifo_empty && eng_ready) begin
                    pop          = 1'b1;
                    cmd_valid_d  = 1'b1;
                    cmd_opcode_d = head_entry[59:52];
                    cmd_slot_d   = head_entry[51:48];
                    cmd_addr_d   = head_entry[47:0];
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wait_cnt_d = '0;
                state_d    = S_WAIT_LOW;
            end
            S_WAIT_LOW: begin
                if (!eng_ready) begin
                    wait_cnt_d = '0;
                    state_d    = S_WAIT_HIGH;
                end else if (wait_cnt_q == TIMEOUT_LAST) begin
                    timeout_evt = 1'b1;
                    wait_cnt_d  = '0;
                    state_d     = S_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_ONE;
                end
            end
            S_WAIT_HIGH: begin
                if (eng_ready) begin
                    done_pulse_d = 1'b1;
                    done_count_d = done_count_q + 32'd1;
                    state_d      = S_IDLE;
                end else if (wait_cnt_q == TIMEOUT_LAST) begin
                    timeout_evt = 1'b1;
                    wait_cnt_d  = '0;
                    state_d     = S_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase
    end

    // A new error event in the same cycle as err_clr keeps the flag set.
    always_comb begin
        err_illegal_d = err_illegal_q;
        err_timeout_d = err_timeout_q;
        if (err_clr) begin
            err_illegal_d = 1'b0;
            err_timeout_d = 1'b0;
        end
        if (illegal_evt) begin
            err_illegal_d = 1'b1;
        end
        if (timeout_evt) begin
            err_timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            cmd_valid_q   <= 1'b0;
            cmd_opcode_q  <= '0;
            cmd_slot_q    <= '0;
            cmd_addr_q    <= '0;
            wait_cnt_q    <= '0;
            done_pulse_q  <= 1'b0;
            done_count_q  <= '0;
            err_illegal_q <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            level_q       <= level_d;
            cmd_valid_q   <= cmd_valid_d;
            cmd_opcode_q  <= cmd_opcode_d;
            cmd_slot_q    <= cmd_slot_d;
            cmd_addr_q    <= cmd_addr_d;
            wait_cnt_q    <= wait_cnt_d;
            done_pulse_q  <= done_pulse_d;
            done_count_q  <= done_count_d;
            err_illegal_q <= err_illegal_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    always_comb begin
        host_ready       = !fifo_full;
        eng_cmd_valid    = cmd_valid_q;
        eng_cmd_opcode   = cmd_opcode_q;
        eng_cmd_slot     = cmd_slot_q;
        eng_cmd_dma_addr = cmd_addr_q;
        queue_level      = level_q;
        idle             = fifo_empty && (state_q == S_IDLE);
        done_pulse       = done_pulse_q;
        done_count       = done_count_q;
        err_illegal      = err_illegal_q;
        err_timeout      = err_timeout_q;
    end

endmodule

// File: tb/tb_ntt_cmd_dispatcher.sv
// Randomised and directed bench for ntt_cmd_dispatcher; a transaction-level
// queue model predicts issue order, completions and sticky error flags.
module tb_ntt_cmd_dispatcher;

    localparam int DEPTH = 8;
    localparam int LW    = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [7:0]  op;
        logic [3:0]  slot;
        logic [47:0] addr;
    } cmd_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          err_clr;
    logic [7:0]    host_opcode;
    logic [3:0]    host_slot;
    logic [47:0]   host_dma_addr;

    logic          host_valid, host_ready;
    logic          eng_cmd_valid;
    logic [7:0]    eng_cmd_opcode;
    logic [3:0]    eng_cmd_slot;
    logic [47:0]   eng_cmd_dma_addr;
    logic          eng_ready;
    logic [LW-1:0] queue_level;
    logic          idle, done_pulse, err_illegal, err_timeout;
    logic [31:0]   done_count;

    logic          host_valid_t, host_ready_t;
    logic          eng_cmd_valid_t;
    logic [7:0]    eng_cmd_opcode_t;
    logic [3:0]    eng_cmd_slot_t;
    logic [47:0]   eng_cmd_dma_addr_t;
    logic          eng_ready_t;
    logic [LW-1:0] queue_level_t;
    logic          idle_t, done_pulse_t, err_illegal_t, err_timeout_t;
    logic [31:0]   done_count_t;

    cmd_t exp_q[$];
    int   exp_done;
    logic exp_illegal;
    int   pulse_seen;
    int   low_left;
    int   eng_low_fixed;
    bit   eng_auto;
    int   checks;
    int   errors;

    ntt_cmd_dispatcher #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .host_valid(host_valid), .host_ready(host_ready),
        .host_opcode(host_opcode), .host_slot(host_slot), .host_dma_addr(host_dma_addr),
        .eng_cmd_valid(eng_cmd_valid), .eng_cmd_opcode(eng_cmd_opcode),
        .eng_cmd_slot(eng_cmd_slot), .eng_cmd_dma_addr(eng_cmd_dma_addr),
        .eng_ready(eng_ready), .err_clr(err_clr),
        .queue_level(queue_level), .idle(idle),
        .done_pulse(done_pulse), .done_count(done_count),
        .err_illegal(err_illegal), .err_timeout(err_timeout)
    );

    ntt_cmd_dispatcher #(.DEPTH(DEPTH), .TIMEOUT(16)) dut_t (
        .clk(clk), .rst(rst),
        .host_valid(host_valid_t), .host_ready(host_ready_t),
        .host_opcode(host_opcode), .host_slot(host_slot), .host_dma_addr(host_dma_addr),
        .eng_cmd_valid(eng_cmd_valid_t), .eng_cmd_opcode(eng_cmd_opcode_t),
        .eng_cmd_slot(eng_cmd_slot_t), .eng_cmd_dma_addr(eng_cmd_dma_addr_t),
        .eng_ready(eng_ready_t), .err_clr(err_clr),
        .queue_level(queue_level_t), .idle(idle_t),
        .done_pulse(done_pulse_t), .done_count(done_count_t),
        .err_illegal(err_illegal_t), .err_timeout(err_timeout_t)
    );

    always #5 clk = ~clk;

    function automatic bit isLegal(input logic [7:0] op);
        return (op == 8'h02) || (op == 8'h03) || (op == 8'h10) || (op == 8'h11);
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // One clock of bench time: score any issue strobe against the model queue,
    // count done pulses, and step the behavioural engine when it is enabled.
    task automatic tick();
        cmd_t e;
        @(negedge clk);
        if (eng_cmd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_issue", 64'(eng_cmd_valid), 64'd0);
            end else begin
                e = exp_q.pop_front();
                checkOutput("issue_opcode", 64'(eng_cmd_opcode), 64'(e.op));
                checkOutput("issue_slot", 64'(eng_cmd_slot), 64'(e.slot));
                checkOutput("issue_addr", 64'(eng_cmd_dma_addr), 64'(e.addr));
            end
        end
        if (done_pulse === 1'b1) pulse_seen++;
        if (eng_auto) begin
            if (eng_cmd_valid === 1'b1) begin
                eng_ready = 1'b0;
                low_left  = (eng_low_fixed > 0) ? eng_low_fixed : int'($urandom_range(2, 6));
            end else if (low_left > 0) begin
                low_left--;
                if (low_left == 0) begin
                    eng_ready = 1'b1;
                    exp_done++;
                end
            end
        end
    endtask

    task automatic applyStimulus(input logic [7:0] op, input logic [3:0] slot,
                                 input logic [47:0] addr);
        cmd_t c;
        host_opcode   = op;
        host_slot     = slot;
        host_dma_addr = addr;
        host_valid    = 1'b1;
        for (int i = 0; i < 2000 && host_ready !== 1'b1; i++) tick();
        checkOutput("host_ready_wait", 64'(host_ready), 64'd1);
        tick();
        host_valid = 1'b0;
        if (isLegal(op)) begin
            c.op = op; c.slot = slot; c.addr = addr;
            exp_q.push_back(c);
        end else begin
            exp_illegal = 1'b1;
        end
    endtask

    task automatic waitIdle(input int bound);
        for (int i = 0; i < bound; i++) begin
            if (idle === 1'b1 && exp_q.size() == 0 && low_left == 0) break;
            tick();
        end
        tick();
        checkOutput("drain_idle", 64'(idle), 64'd1);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_level"}, 64'(queue_level), 64'd0);
        checkOutput({tag, "_valid"}, 64'(eng_cmd_valid), 64'd0);
        checkOutput({tag, "_opcode"}, 64'(eng_cmd_opcode), 64'd0);
        checkOutput({tag, "_slot"}, 64'(eng_cmd_slot), 64'd0);
        checkOutput({tag, "_addr"}, 64'(eng_cmd_dma_addr), 64'd0);
        checkOutput({tag, "_done_pulse"}, 64'(done_pulse), 64'd0);
        checkOutput({tag, "_done_count"}, 64'(done_count), 64'd0);
        checkOutput({tag, "_err_illegal"}, 64'(err_illegal), 64'd0);
        checkOutput({tag, "_err_timeout"}, 64'(err_timeout), 64'd0);
        checkOutput({tag, "_idle"}, 64'(idle), 64'd1);
        checkOutput({tag, "_host_ready"}, 64'(host_ready), 64'd1);
    endtask

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0]  legal_ops [4];
        logic [7:0]  op;
        logic [63:0] r64;
        int          base;
        int          r;

        legal_ops     = '{8'h02, 8'h03, 8'h10, 8'h11};
        rst           = 1'b0;
        err_clr       = 1'b0;
        host_valid    = 1'b0;
        host_valid_t  = 1'b0;
        host_opcode   = '0;
        host_slot     = '0;
        host_dma_addr = '0;
        eng_ready     = 1'b1;
        eng_ready_t   = 1'b1;
        eng_auto      = 1'b1;
        eng_low_fixed = 0;
        low_left      = 0;
        exp_done      = 0;
        exp_illegal   = 1'b0;
        pulse_seen    = 0;
        checks        = 0;
        errors        = 0;

        @(negedge clk);
        rst = 1'b1;
        #1;
        checkResetValues("reset");
        tick();
        rst = 1'b0;
        tick();

        // Single LOAD: strobe one cycle wide, two cycles after acceptance.
        eng_low_fixed = 2;
        applyStimulus(8'h02, 4'd1, 48'h1000);
        checkOutput("lat_before", 64'(eng_cmd_valid), 64'd0);
        tick();
        checkOutput("lat_strobe", 64'(eng_cmd_valid), 64'd1);
        tick();
        checkOutput("lat_after", 64'(eng_cmd_valid), 64'd0);
        waitIdle(100);
        checkOutput("load_done_count", 64'(done_count), 64'(exp_done));
        checkOutput("load_pulses", 64'(pulse_seen), 64'(exp_done));
        checkOutput("load_payload_hold", 64'(eng_cmd_slot), 64'd1);
        eng_low_fixed = 0;

        // Fill the queue with the engine busy, then release it.
        eng_auto  = 1'b0;
        eng_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(legal_ops[i % 4], 4'(i), 48'hA000 + 48'(i));
        end
        checkOutput("full_level", 64'(queue_level), 64'(DEPTH));
        checkOutput("full_host_ready", 64'(host_ready), 64'd0);
        host_opcode   = 8'h11;
        host_slot     = 4'd9;
        host_dma_addr = 48'hBEEF;
        host_valid    = 1'b1;
        repeat (3) tick();
        checkOutput("full_hold_level", 64'(queue_level), 64'(DEPTH));
        eng_ready = 1'b1;
        eng_auto  = 1'b1;
        applyStimulus(8'h11, 4'd9, 48'hBEEF);
        waitIdle(500);
        checkOutput("fill_done_count", 64'(done_count), 64'(exp_done));
        checkOutput("fill_pulses", 64'(pulse_seen), 64'(exp_done));

        // Illegal opcode is dropped and flagged; err_clr vs new error.
        applyStimulus(8'h55, 4'd2, 48'h2222);
        checkOutput("illegal_flag", 64'(err_illegal), 64'(exp_illegal));
        checkOutput("illegal_level", 64'(queue_level), 64'd0);
        applyStimulus(8'h10, 4'd3, 48'h3333);
        checkOutput("ntt_level", 64'(queue_level), 64'd1);
        waitIdle(100);
        checkOutput("illegal_done_count", 64'(done_count), 64'(exp_done));
        err_clr = 1'b1;
        tick();
        err_clr     = 1'b0;
        exp_illegal = 1'b0;
        checkOutput("illegal_cleared", 64'(err_illegal), 64'(exp_illegal));
        host_opcode = 8'hEE;
        host_valid  = 1'b1;
        err_clr     = 1'b1;
        tick();
        host_valid  = 1'b0;
        err_clr     = 1'b0;
        exp_illegal = 1'b1;
        checkOutput("set_beats_clear", 64'(err_illegal), 64'(exp_illegal));

        // Randomised mix of legal and illegal commands with random engine delays.
        for (int i = 0; i < 40; i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 8) begin
                op = legal_ops[r % 4];
            end else begin
                op = 8'($urandom());
                if (isLegal(op)) op = op ^ 8'h80;
            end
            r64 = {$urandom(), $urandom()};
            applyStimulus(op, 4'($urandom()), r64[47:0]);
            repeat ($urandom_range(0, 3)) tick();
        end
        waitIdle(2000);
        checkOutput("rand_done_count", 64'(done_count), 64'(exp_done));
        checkOutput("rand_pulses", 64'(pulse_seen), 64'(exp_done));
        checkOutput("rand_err_illegal", 64'(err_illegal), 64'(exp_illegal));
        checkOutput("rand_err_timeout", 64'(err_timeout), 64'd0);

        // Long INTT well inside the default timeout.
        base          = pulse_seen;
        eng_low_fixed = 30000;
        applyStimulus(8'h11, 4'd3, 48'h7777_0000_0001);
        waitIdle(31000);
        eng_low_fixed = 0;
        checkOutput("long_err_timeout", 64'(err_timeout), 64'd0);
        checkOutput("long_pulses", 64'(pulse_seen - base), 64'd1);
        checkOutput("long_done_count", 64'(done_count), 64'(exp_done));

        // TIMEOUT=16 instance: ready stuck high in WAIT_LOW.
        host_opcode   = 8'h10;
        host_slot     = 4'd5;
        host_dma_addr = 48'h5555_0000_1234;
        host_valid_t  = 1'b1;
        tick();
        host_valid_t = 1'b0;
        tick();
        checkOutput("t_strobe", 64'(eng_cmd_valid_t), 64'd1);
        checkOutput("t_opcode", 64'(eng_cmd_opcode_t), 64'h10);
        checkOutput("t_addr", 64'(eng_cmd_dma_addr_t), 64'h5555_0000_1234);
        repeat (16) tick();
        checkOutput("t_low_before", 64'(err_timeout_t), 64'd0);
        tick();
        checkOutput("t_low_flag", 64'(err_timeout_t), 64'd1);
        checkOutput("t_low_idle", 64'(idle_t), 64'd1);
        checkOutput("t_low_done_count", 64'(done_count_t), 64'd0);

        host_opcode  = 8'h02;
        host_slot    = 4'd6;
        host_valid_t = 1'b1;
        tick();
        host_valid_t = 1'b0;
        tick();
        checkOutput("t_next_strobe", 64'(eng_cmd_valid_t), 64'd1);
        eng_ready_t = 1'b0;
        repeat (2) tick();
        eng_ready_t = 1'b1;
        repeat (3) tick();
        checkOutput("t_next_done_count", 64'(done_count_t), 64'd1);
        checkOutput("t_sticky", 64'(err_timeout_t), 64'd1);
        err_clr = 1'b1;
        tick();
        err_clr     = 1'b0;
        exp_illegal = 1'b0;
        checkOutput("t_cleared", 64'(err_timeout_t), 64'd0);
        checkOutput("main_cleared", 64'(err_illegal), 64'(exp_illegal));

        // TIMEOUT=16 instance: ready stuck low in WAIT_HIGH.
        host_opcode  = 8'h03;
        host_slot    = 4'd7;
        host_valid_t = 1'b1;
        tick();
        host_valid_t = 1'b0;
        tick();
        checkOutput("t_high_strobe", 64'(eng_cmd_valid_t), 64'd1);
        eng_ready_t = 1'b0;
        repeat (17) tick();
        checkOutput("t_high_before", 64'(err_timeout_t), 64'd0);
        tick();
        checkOutput("t_high_flag", 64'(err_timeout_t), 64'd1);
        checkOutput("t_high_idle", 64'(idle_t), 64'd1);
        eng_ready_t = 1'b1;
        repeat (3) tick();
        checkOutput("t_high_done_count", 64'(done_count_t), 64'd1);

        // Reset while waiting on the engine with three commands queued.
        eng_auto  = 1'b0;
        eng_ready = 1'b1;
        applyStimulus(8'h10, 4'd9, 48'h9999);
        tick();
        checkOutput("rst_strobe", 64'(eng_cmd_valid), 64'd1);
        eng_ready = 1'b0;
        repeat (2) tick();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(legal_ops[i], 4'(i + 10), 48'hC000 + 48'(i));
        end
        checkOutput("rst_pre_level", 64'(queue_level), 64'd3);
        checkOutput("rst_pre_idle", 64'(idle), 64'd0);
        rst = 1'b1;
        #1;
        checkResetValues("midrst");
        exp_q.delete();
        exp_done    = 0;
        exp_illegal = 1'b0;
        base        = pulse_seen;
        tick();
        rst       = 1'b0;
        eng_ready = 1'b1;
        repeat (5) tick();
        checkOutput("post_rst_pulses", 64'(pulse_seen - base), 64'd0);
        checkOutput("post_rst_done_count", 64'(done_count), 64'(exp_done));
        checkOutput("post_rst_level", 64'(queue_level), 64'd0);
        checkOutput("post_rst_idle", 64'(idle), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
